lstm_seq_controller: RTL and testbench

//  Sequences a stream of input samples through one lstm_cell instance, one timestep at a time.

---
 rtl/lstm_seq_controller.sv | 148 ++++++++++++++
 tb/tb_lstm_seq_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_seq_controller.sv
`default_nettype none
// ============================================================================
//  Module   : lstm_seq_controller
//  Purpose  : Feeds one input sample at a time through an external lstm_cell.
//             Holds the recurrent h/c state, waits out the cell latency and
//             returns the final hidden state of each sequence over a
//             valid/ready stream.
//  Revision : 1.0 - initial release
// ============================================================================
module lstm_seq_controller #(
  parameter int N            = 8,
  parameter int HIDDEN_SIZE  = 64,
  parameter int CELL_LATENCY = 1,
  parameter int MAX_STEPS    = 256,
  parameter int CNT_W        = $clog2(MAX_STEPS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_data,
  input  logic                   in_last,
  output logic [N-1:0]           cell_x,
  output logic [HIDDEN_SIZE-1:0] cell_h_prev,
  output logic [HIDDEN_SIZE-1:0] cell_c_prev,
  input  logic [HIDDEN_SIZE-1:0] cell_h_t,
  input  logic [HIDDEN_SIZE-1:0] cell_c_t,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [HIDDEN_SIZE-1:0] out_h,
  output logic [CNT_W-1:0]       out_steps,
  output logic                   out_trunc,
  output logic                   busy
);

  // Wait counter must hold CELL_LATENCY itself (counts down to 1).
  localparam int WAIT_W = $clog2(CELL_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [N-1:0]           x_q, x_d;
  logic [HIDDEN_SIZE-1:0] h_q, h_d;
  logic [HIDDEN_SIZE-1:0] c_q, c_d;
  logic [CNT_W-1:0]       step_q, step_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   last_q, last_d;
  logic                   first_q, first_d;
  logic [CNT_W-1:0]       step_inc;

  assign step_inc = step_q + CNT_W'(1);

  // State and datapath registers; reset aborts any sequence and pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      h_q     <= '0;
      c_q     <= '0;
      step_q  <= '0;
      wait_q  <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      h_q     <= h_d;
      c_q     <= c_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

  // Next-state logic: accept, wait for the cell, capture, then present result.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    h_d     = h_q;
    c_d     = c_q;
    step_d  = step_q;
    wait_d  = wait_q;
    last_d  = last_q;
    first_d = first_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d    = in_data;
          last_d = in_last;
          // A new sequence starts from zeroed recurrent state.
          if (first_q) begin
            h_d     = '0;
            c_d     = '0;
            first_d = 1'b0;
          end
          wait_d  = WAIT_W'(CELL_LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_W'(1)) begin
          state_d = S_CAPTURE;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_CAPTURE: begin
        h_d    = cell_h_t;
        c_d    = cell_c_t;
        step_d = step_inc;
        if (last_q || (step_inc == CNT_W'(MAX_STEPS))) begin
          state_d = S_OUTPUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          step_d  = '0;
          first_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Cell operands come straight from registers so they stay stable in WAIT.
  assign cell_x      = x_q;
  assign cell_h_prev = h_q;
  assign cell_c_prev = c_q;

  // Result fields are only driven while a result is on offer.
  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign out_valid = (state_q == S_OUTPUT);
  assign out_h     = out_valid ? h_q : '0;
  assign out_steps = out_valid ? step_q : '0;
  assign out_trunc = out_valid && !last_q;
  assign busy      = (state_q != S_IDLE) || !first_q;

endmodule
`default_nettype wire

// File: tb/tb_lstm_seq_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lstm_seq_controller
//  Purpose  : Directed self-checking bench for lstm_seq_controller with a
//             behavioural one-cycle lstm_cell stand-in.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lstm_seq_controller;

  localparam int N  = 8;
  localparam int HS = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: CELL_LATENCY=1, MAX_STEPS=4 ----------------
  logic          in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [N-1:0]  in_data = '0, cell_x;
  logic [HS-1:0] cell_h_prev, cell_c_prev, cell_h_t, cell_c_t, out_h;
  logic          out_valid, out_ready = 1'b0, out_trunc, busy;
  logic [2:0]    out_steps;
  logic          mode = 1'b0;   // 0: h=c=x replicated, 1: h=h_prev+1, c=c_prev+1

  lstm_seq_controller #(.N(N), .HIDDEN_SIZE(HS), .CELL_LATENCY(1), .MAX_STEPS(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .cell_x(cell_x),
    .cell_h_prev(cell_h_prev), .cell_c_prev(cell_c_prev),
    .cell_h_t(cell_h_t), .cell_c_t(cell_c_t), .out_valid(out_valid),
    .out_ready(out_ready), .out_h(out_h), .out_steps(out_steps),
    .out_trunc(out_trunc), .busy(busy)
  );

  always @(posedge clk) begin
    if (mode == 1'b0) begin
      cell_h_t <= {8{cell_x}};
      cell_c_t <= {8{cell_x}};
    end else begin
      cell_h_t <= cell_h_prev + 64'd1;
      cell_c_t <= cell_c_prev + 64'd1;
    end
  end

  // ---------------- DUT B: CELL_LATENCY=3, MAX_STEPS=3 ----------------
  logic          in_valid3 = 1'b0, in_ready3;
  logic [N-1:0]  cell_x3;
  logic [HS-1:0] h_prev3, c_prev3, h_t3, c_t3, out_h3;
  logic          out_valid3, out_ready3 = 1'b0, out_trunc3, busy3;
  logic [1:0]    out_steps3;

  lstm_seq_controller #(.N(N), .HIDDEN_SIZE(HS), .CELL_LATENCY(3), .MAX_STEPS(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(8'h22), .in_last(1'b0), .cell_x(cell_x3),
    .cell_h_prev(h_prev3), .cell_c_prev(c_prev3),
    .cell_h_t(h_t3), .cell_c_t(c_t3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_h(out_h3), .out_steps(out_steps3),
    .out_trunc(out_trunc3), .busy(busy3)
  );

  always @(posedge clk) begin
    h_t3 <= h_prev3 + 64'd1;
    c_t3 <= c_prev3 + 64'd1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a sample at a negedge; return at the negedge after it is accepted.
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Take the pending result; returns at the negedge after the handshake.
  task automatic take();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("take_timeout", 64'd0, 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int acc[$];
    int ov;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_h_prev", cell_h_prev, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // ---- 1: single step, h=c=x replicated ----
    mode = 1'b0;
    send(8'h10, 1'b1);
    chk("t1_h_prev", cell_h_prev, 0);
    chk("t1_cell_x", cell_x, 64'h10);
    chk("t1_in_ready_wait", in_ready, 0);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_ov_capture", out_valid, 0);
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_h", out_h, 64'h1010101010101010);
    chk("t1_out_steps", out_steps, 1);
    chk("t1_out_trunc", out_trunc, 0);
    chk("t1_no_ready", in_ready, 0);
    take();
    chk("t1_after_ov", out_valid, 0);
    chk("t1_after_busy", busy, 0);

    // ---- 2: three steps, h_t=h_prev+1 ----
    mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(8'h30 + 8'(i), i == 2);
      chk($sformatf("t2_h_prev%0d", i), cell_h_prev, 64'(i));
      chk($sformatf("t2_rdy_wait%0d", i), in_ready, 0);
      @(negedge clk);
      chk($sformatf("t2_rdy_cap%0d", i), in_ready, 0);
      @(negedge clk);
      chk($sformatf("t2_rdy_after%0d", i), in_ready, (i < 2) ? 64'd1 : 64'd0);
    end
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_h", out_h, 3);
    chk("t2_out_steps", out_steps, 3);
    chk("t2_out_trunc", out_trunc, 0);

    // ---- 3: backpressure for 5 cycles, then fresh sequence ----
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_ov_hold", out_valid, 1);
      chk("t3_h_hold", out_h, 3);
      chk("t3_steps_hold", out_steps, 3);
      chk("t3_rdy_low", in_ready, 0);
    end
    take();
    send(8'h01, 1'b1);
    chk("t3_fresh_h", cell_h_prev, 0);
    chk("t3_fresh_c", cell_c_prev, 0);
    take();

    // ---- 4: truncation at MAX_STEPS=4, then fresh state ----
    for (int i = 0; i < 4; i++) begin
      send(8'h40 + 8'(i), 1'b0);
      chk($sformatf("t4_h_prev%0d", i), cell_h_prev, 64'(i));
    end
    repeat (2) @(negedge clk);
    chk("t4_out_valid", out_valid, 1);
    chk("t4_out_steps", out_steps, 4);
    chk("t4_out_trunc", out_trunc, 1);
    chk("t4_out_h", out_h, 4);
    take();
    send(8'h50, 1'b0);
    chk("t4_5th_h_prev", cell_h_prev, 0);
    chk("t4_5th_c_prev", cell_c_prev, 0);
    send(8'h51, 1'b0);
    chk("t4_6th_h_prev", cell_h_prev, 1);

    // ---- 5: reset in WAIT of step 2 ----
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rdy_in_rst", in_ready, 0);
    chk("t5_ov", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_h_prev", cell_h_prev, 0);
    chk("t5_cell_x", cell_x, 0);
    chk("t5_steps", out_steps, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rdy_after", in_ready, 1);
    chk("t5_no_ov", out_valid, 0);
    send(8'h05, 1'b1);
    repeat (2) @(negedge clk);
    chk("t5_ov_1step", out_valid, 1);
    chk("t5_steps_1", out_steps, 1);
    chk("t5_h_1", out_h, 1);
    take();

    // ---- in_last on sample MAX_STEPS: last wins ----
    for (int i = 0; i < 4; i++) send(8'h60 + 8'(i), i == 3);
    repeat (2) @(negedge clk);
    chk("lw_ov", out_valid, 1);
    chk("lw_steps", out_steps, 4);
    chk("lw_trunc", out_trunc, 0);
    take();

    // ---- 6: in_valid held, CELL_LATENCY=3, MAX_STEPS=3 ----
    ov = -1;
    in_valid3 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (in_ready3) acc.push_back(c);
      if (out_valid3 && ov < 0) ov = c;
      chk("t6_exclusive", in_ready3 & out_valid3, 0);
      @(negedge clk);
    end
    in_valid3 = 1'b0;
    chk("t6_num_accepts", acc.size(), 3);
    if (acc.size() >= 3) begin
      chk("t6_first_acc", acc[0], 0);
      chk("t6_gap1", acc[1] - acc[0], 5);
      chk("t6_gap2", acc[2] - acc[1], 5);
      chk("t6_ov_time", ov, acc[2] + 5);
    end
    chk("t6_steps", out_steps3, 3);
    chk("t6_trunc", out_trunc3, 1);
    chk("t6_out_h", out_h3, 3);
    out_ready3 = 1'b1;
    @(negedge clk);
    out_ready3 = 1'b0;
    chk("t6_done_busy", busy3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
